// File: rtl/fib_pkg.sv
// rtl/fib_pkg.sv - shared state encoding and seed constant for the Fibonacci engine
package fib_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } fib_state_e;

    localparam int FIB_SEED = 1;

endpackage

// File: rtl/fib_seq_engine_if.sv
// rtl/fib_seq_engine_if.sv - request/response bundle between FBC execute stage and engine
interface fib_seq_engine_if #(
    parameter int DATA_W = 16,
    parameter int N_W    = 16
);
    logic              start;
    logic [N_W-1:0]    n;
    logic              mode;
    logic [DATA_W-1:0] seed_a;
    logic [DATA_W-1:0] seed_b;
    logic              abort;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] result;
    logic              overflow;

    modport master (
        output start, n, mode, seed_a, seed_b, abort,
        input  busy, done, result, overflow
    );

    modport slave (
        input  start, n, mode, seed_a, seed_b, abort,
        output busy, done, result, overflow
    );
endinterface

// File: rtl/fib_step_add.sv
// rtl/fib_step_add.sv - one recurrence step: a+b with carry-out and saturation to all-ones
module fib_step_add #(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] next_b,
    output logic              carry
);
    logic [DATA_W:0] sum;

    assign sum    = {1'b0, a} + {1'b0, b};
    assign carry  = sum[DATA_W];
    assign next_b = carry ? {DATA_W{1'b1}} : sum[DATA_W-1:0];
endmodule

// File: rtl/fib_seq_engine.sv
// rtl/fib_seq_engine.sv - self-sequencing recurrence engine: term n from two seeds
module fib_seq_engine
    import fib_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int N_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    fib_seq_engine_if.slave   bus
);
    fib_state_e        state_q, state_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [N_W-1:0]    k_q, k_d;
    logic [N_W-1:0]    nq_q, nq_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              ovf_q, ovf_d;

    logic [DATA_W-1:0] seed_a_sel;
    logic [DATA_W-1:0] seed_b_sel;
    logic [DATA_W-1:0] step_b;
    logic              step_carry;
    logic [N_W-1:0]    k_inc;

    assign seed_a_sel = bus.mode ? bus.seed_a : DATA_W'(FIB_SEED);
    assign seed_b_sel = bus.mode ? bus.seed_b : DATA_W'(FIB_SEED);
    // k stays below n_q, so the increment never wraps
    assign k_inc      = k_q + N_W'(1);

    fib_step_add #(
        .DATA_W (DATA_W)
    ) u_step (
        .a      (a_q),
        .b      (b_q),
        .next_b (step_b),
        .carry  (step_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            k_q      <= '0;
            nq_q     <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            k_q      <= k_d;
            nq_q     <= nq_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
        end
    end

    // result/overflow are loaded on the edge entering DONE so they are valid alongside done
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        k_d      = k_q;
        nq_d     = nq_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    nq_d  = bus.n;
                    a_d   = seed_a_sel;
                    b_d   = seed_b_sel;
                    k_d   = N_W'(1);
                    ovf_d = 1'b0;
                    if (bus.n <= N_W'(1)) begin
                        state_d  = ST_DONE;
                        result_d = (bus.n == '0) ? seed_a_sel : seed_b_sel;
                    end else begin
                        state_d = ST_ITER;
                    end
                end
            end
            ST_ITER: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else begin
                    a_d = b_q;
                    b_d = step_b;
                    k_d = k_inc;
                    if (step_carry || (k_inc == nq_q)) begin
                        state_d  = ST_DONE;
                        result_d = step_b;
                        ovf_d    = step_carry;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.busy     = (state_q == ST_ITER);
    assign bus.done     = (state_q == ST_DONE);
    assign bus.result   = result_q;
    assign bus.overflow = ovf_q;

endmodule
